// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time, period and integer duty percentage
// of an asynchronous PWM line. Each period is timed between rising edges.
// A 7-step restoring divider produces floor(high*100/period).
// Lines that stop toggling are reported through a timeout result, which
// does not go through the divider.
// Optional build macro: PWM_METER_DEGLITCH_EN. It adds a 3-cycle hold filter
// after the synchronizer.
module pwm_duty_meter #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);
  localparam int NUM_W = CNT_W + 7;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_WAIT, S_HIGH, S_LOW, S_STUCK} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_pwm;
  logic                   s_prev_q;
  logic                   rise, fall;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       hi_snap_q;
  logic                   tmo_pend_q;
  logic                   tmo_lvl_q;
  logic                   exp_edge;
  logic                   tmo_hit;
  logic                   snap_go;

  logic [NUM_W-1:0]       rem_q, dsh_q, rem_d;
  logic [6:0]             quo_q, quo_d;
  logic [2:0]             it_q;
  logic [CNT_W-1:0]       hi_op_q, per_op_q;
  logic                   ge;

  logic [CNT_W-1:0]       high_q, period_q;
  logic [6:0]             duty_q;
  logic                   valid_q, timeout_q, busy_q;

  // Input synchronizer chain for the asynchronous PWM line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

`ifdef PWM_METER_DEGLITCH_EN
  logic       filt_q;
  logic [1:0] hold_q;

  // Level filter: follow the synchronized input only after 3 stable cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      hold_q <= '0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      hold_q <= '0;
    end else if (hold_q == 2'd2) begin
      filt_q <= sync_q[SYNC_STAGES-1];
      hold_q <= '0;
    end else begin
      hold_q <= hold_q + 2'd1;
    end
  end

  assign s_pwm = filt_q;
`else
  assign s_pwm = sync_q[SYNC_STAGES-1];
`endif

  // Previous filtered level, used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_prev_q <= 1'b0;
    else        s_prev_q <= s_pwm;
  end

  assign rise = s_pwm & ~s_prev_q;
  assign fall = ~s_pwm & s_prev_q;

  // Work out which edge the current state waits for
  always_comb begin
    exp_edge = 1'b0;
    case (state_q)
      S_WAIT, S_LOW: exp_edge = rise;
      S_HIGH:        exp_edge = fall;
      default:       exp_edge = 1'b0;
    endcase
  end

  // >= rather than ==: a falling edge landing exactly on the limit pushes cnt one past it
  assign tmo_hit = (state_q != S_STUCK) && (cnt_q >= TMO) && !exp_edge;
  assign snap_go = (state_q == S_LOW) && rise;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Measurement FSM: period counter, high-time snapshot, stuck detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT;
      cnt_q      <= '0;
      hi_snap_q  <= '0;
      tmo_pend_q <= 1'b0;
      tmo_lvl_q  <= 1'b0;
    end else begin
      tmo_pend_q <= 1'b0;
      if (tmo_hit) begin
        state_q    <= S_STUCK;
        tmo_pend_q <= 1'b1;
        tmo_lvl_q  <= s_pwm;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (rise) begin
              state_q <= S_HIGH;
              cnt_q   <= CNT_W'(1);
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          S_HIGH: begin
            if (fall) begin
              hi_snap_q <= cnt_q;
              state_q   <= S_LOW;
            end
            cnt_q <= cnt_inc;
          end
          S_LOW: begin
            if (rise) begin
              state_q <= S_HIGH;
              cnt_q   <= CNT_W'(1);
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            // S_STUCK: hold the count until the line moves again
            if (rise) begin
              state_q <= S_HIGH;
              cnt_q   <= CNT_W'(1);
            end else if (fall) begin
              state_q <= S_WAIT;
              cnt_q   <= '0;
            end
          end
        endcase
      end
    end
  end

  // One restoring step: the divisor shifts right one bit per step
  always_comb begin
    ge    = (rem_q >= dsh_q);
    rem_d = ge ? rem_q - dsh_q : rem_q;
    quo_d = {quo_q[5:0], ge};
  end

  // Divider sequencing and result registers; a timeout result overrides the divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      dsh_q     <= '0;
      quo_q     <= '0;
      it_q      <= '0;
      hi_op_q   <= '0;
      per_op_q  <= '0;
      high_q    <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tmo_pend_q) begin
        busy_q    <= 1'b0;
        valid_q   <= 1'b1;
        timeout_q <= 1'b1;
        period_q  <= TMO;
        high_q    <= tmo_lvl_q ? TMO : '0;
        duty_q    <= tmo_lvl_q ? 7'd100 : 7'd0;
      end else if (tmo_hit) begin
        busy_q <= 1'b0;
      end else if (busy_q) begin
        rem_q <= rem_d;
        dsh_q <= dsh_q >> 1;
        quo_q <= quo_d;
        it_q  <= it_q + 3'd1;
        if (it_q == 3'd6) begin
          busy_q    <= 1'b0;
          valid_q   <= 1'b1;
          timeout_q <= 1'b0;
          high_q    <= hi_op_q;
          period_q  <= per_op_q;
          duty_q    <= quo_d;
        end
      end else if (snap_go) begin
        busy_q   <= 1'b1;
        it_q     <= '0;
        quo_q    <= '0;
        rem_q    <= NUM_W'(hi_snap_q) * NUM_W'(100);
        dsh_q    <= NUM_W'(cnt_q) << 6;
        hi_op_q  <= hi_snap_q;
        per_op_q <= cnt_q;
      end
    end
  end

  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign duty_pct   = duty_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: table of PWM shapes with hand-computed
// duty and valid counts, plus timeout and mid-division reset sequences.
module tb_pwm_duty_meter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] high_cnt, period_cnt;
  logic [6:0]  duty_pct;
  logic        valid, timeout, busy;

  pwm_duty_meter dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .duty_pct(duty_pct),
    .valid(valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int          v_cyc[$];
  int          v_hi[$], v_per[$], v_duty[$], v_tmo[$];
  int          overlap = 0;
  int          r_cyc[$];

  // Log every valid result, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        v_cyc.push_back(cyc);
        v_hi.push_back(int'(high_cnt));
        v_per.push_back(int'(period_cnt));
        v_duty.push_back(int'(duty_pct));
        v_tmo.push_back(int'(timeout));
      end
      if (valid && busy) overlap++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hold pwm_in at v for n clock cycles; entered and left at posedge+1
  task automatic hold(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    v_cyc.delete(); v_hi.delete(); v_per.delete(); v_duty.delete(); v_tmo.delete();
    r_cyc.delete();
    overlap = 0;
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b0, 5);
  endtask

  typedef struct {
    int hi;
    int per;
    int nper;
    int duty;
    int nval;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{25, 100, 3, 25, 3};
    vecs[1] = '{1,  100, 2, 1,  2};
    vecs[2] = '{99, 100, 2, 99, 2};
    vecs[3] = '{1,  3,   1, 33, 1};
    vecs[4] = '{2,  3,   1, 66, 1};
    vecs[5] = '{2,  5,   4, 40, 2};   // every other closing edge dropped
    vecs[6] = '{3,  7,   4, 42, 2};   // gap 7: still busy, dropped
    vecs[7] = '{3,  8,   3, 37, 3};   // gap 8: divider just free
    vecs[8] = '{7,  9,   3, 77, 3};
    vecs[9] = '{50, 100, 1, 50, 1};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", valid, 0);
    check("reset busy", busy, 0);
    check("reset timeout", timeout, 0);
    check("reset duty", duty_pct, 0);
    check("reset high", high_cnt, 0);
    check("reset period", period_cnt, 0);

    // Table-driven periodic waveforms
    for (int i = 0; i < 10; i++) begin
      do_reset();
      clear_log();
      hold(1'b1, vecs[i].hi);
      hold(1'b0, vecs[i].per - vecs[i].hi);
      for (int k = 0; k < vecs[i].nper; k++) begin
        r_cyc.push_back(cyc);
        hold(1'b1, vecs[i].hi);
        if (k < vecs[i].nper - 1) hold(1'b0, vecs[i].per - vecs[i].hi);
      end
      hold(1'b0, 20);
      check($sformatf("v%0d nvalid", i), v_cyc.size(), vecs[i].nval);
      for (int j = 0; j < v_cyc.size() && j < vecs[i].nval; j++) begin
        check($sformatf("v%0d[%0d] duty", i, j), v_duty[j], vecs[i].duty);
        check($sformatf("v%0d[%0d] high", i, j), v_hi[j], vecs[i].hi);
        check($sformatf("v%0d[%0d] period", i, j), v_per[j], vecs[i].per);
        check($sformatf("v%0d[%0d] timeout", i, j), v_tmo[j], 0);
      end
      if (v_cyc.size() > 0)
        check($sformatf("v%0d latency", i), v_cyc[0] - r_cyc[0], 10);
      check($sformatf("v%0d valid/busy overlap", i), overlap, 0);
    end

    // Stuck high, then recovery with a normal period
    do_reset();
    clear_log();
    hold(1'b1, 1200);
    check("stuck hi timeout level", timeout, 1);
    hold(1'b0, 50);
    check("stuck hi timeout held", timeout, 1);
    hold(1'b1, 50);
    hold(1'b0, 50);
    hold(1'b1, 5);
    hold(1'b0, 20);
    check("stuck hi nvalid", v_cyc.size(), 2);
    if (v_cyc.size() >= 2) begin
      check("stuck hi tmo flag", v_tmo[0], 1);
      check("stuck hi duty", v_duty[0], 100);
      check("stuck hi high", v_hi[0], 1000);
      check("stuck hi period", v_per[0], 1000);
      check("recover tmo flag", v_tmo[1], 0);
      check("recover duty", v_duty[1], 50);
      check("recover high", v_hi[1], 50);
      check("recover period", v_per[1], 100);
    end
    check("recover timeout level", timeout, 0);

    // Stuck low straight out of reset
    do_reset();
    clear_log();
    hold(1'b0, 1100);
    check("stuck lo nvalid", v_cyc.size(), 1);
    if (v_cyc.size() >= 1) begin
      check("stuck lo tmo flag", v_tmo[0], 1);
      check("stuck lo duty", v_duty[0], 0);
      check("stuck lo high", v_hi[0], 0);
      check("stuck lo period", v_per[0], 1000);
    end
    check("stuck lo timeout level", timeout, 1);

    // Reset while a division is in flight
    do_reset();
    clear_log();
    hold(1'b1, 25);
    hold(1'b0, 75);
    hold(1'b1, 6);
    check("pre-reset busy", busy, 1);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset valid", valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check("mid reset duty", duty_pct, 0);
    check("mid reset period", period_cnt, 0);
    rst_n = 1'b1;
    hold(1'b0, 20);
    check("post reset no valid", v_cyc.size(), 0);
    hold(1'b1, 25);
    hold(1'b0, 75);
    hold(1'b1, 25);
    hold(1'b0, 20);
    check("restart nvalid", v_cyc.size(), 1);
    if (v_cyc.size() >= 1) begin
      check("restart duty", v_duty[0], 25);
      check("restart period", v_per[0], 100);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
Receive-side counterpart to the LED PWM generators. It samples an external or looped-back PWM line, measures high time and period in clk cycles, and computes duty cycle as an integer percent (0-100). It sits between a PWM source and status logic such as displays or self-check. Stuck-high and stuck-low lines are reported through a timeout path.

Parameters:
CNT_W, 16, width of the high-time and period counters
TIMEOUT_CYCLES, 1000, cycles without an expected edge before a timeout result is produced; must be < 2^CNT_W
SYNC_STAGES, 2, input synchronizer depth; must be >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
pwm_in  in  1  asynchronous PWM input
high_cnt  out  CNT_W  high time of the last measured period, in cycles
period_cnt  out  CNT_W  length of the last measured period, rising edge to rising edge
duty_pct  out  7  floor(high_cnt*100/period_cnt), range 0..100
valid  out  1  one-cycle pulse when all three outputs update together
timeout  out  1  level; high while the line is stuck, cleared by the next valid non-timeout result
busy  out  1  divider running

Behaviour:
- One clock domain. rst_n is asynchronous, active-low.
- Reset values: all outputs are 0, synchronizer flops are 0, FSM is in S_WAIT, and all counters are 0.
- pwm_in passes through SYNC_STAGES flops, giving s_pwm. Edges are detected by comparing s_pwm with its previous value. All timing in this spec is relative to s_pwm edges.
- S_WAIT, entered after reset: discard any partial period. On a rising edge, set cnt to 1 and go to S_HIGH.
- S_HIGH: cnt increments each cycle. On a falling edge, latch hi_snap = cnt and go to S_LOW.
- S_LOW: cnt increments. On a rising edge:
  - snapshot hi_snap and per_snap = cnt, then hand both to the divider;
  - reset cnt to 1 and go to S_HIGH.
  Measurement is back-to-back; no period is skipped.
- Divider:
  - restoring, 7 iterations, numerator hi_snap*100 (CNT_W+7 bits), result truncated;
  - busy is high during the iterations;
  - valid pulses exactly 8 cycles after the closing rising edge, with high_cnt, period_cnt and duty_pct updated in the same cycle.
- Simultaneous events: if a snapshot arrives while busy=1, the new snapshot is dropped. The running division completes unaffected and the dropped period produces no valid pulse.
- Timeout: in any state, if cnt reaches TIMEOUT_CYCLES with no expected edge, enter S_STUCK. One cycle later, pulse valid with timeout=1 and:
  - period_cnt = high_cnt = TIMEOUT_CYCLES, duty_pct = 100 if s_pwm=1;
  - period_cnt = TIMEOUT_CYCLES, high_cnt = 0, duty_pct = 0 if s_pwm=0.
  The timeout result bypasses the divider. If the divider is busy at that moment, it is aborted and its result discarded.
- S_STUCK: cnt is held. A rising edge goes to S_HIGH with cnt=1. A falling edge goes to S_WAIT. timeout stays high until the next divider valid.
- cnt never wraps. TIMEOUT_CYCLES bounds it.
- Reset mid-operation: all state returns to reset values immediately, and the in-flight division is discarded without a valid pulse.

Optional Feature:
PWM_METER_DEGLITCH_EN
- Defined: s_pwm is replaced by a filtered level that changes only after the synchronized input holds the new value for 3 consecutive cycles. Both edges are delayed equally, so steady-state counts are unchanged. Pulses of 1-2 cycles are ignored. valid latency relative to pwm_in grows by 3 cycles.
- Undefined: no filter; every synchronized transition counts as an edge.

Test Plan:
- Reset, then pwm_in period 100 with high 25, repeated -> the first full period after the first rising edge gives high_cnt=25, period_cnt=100, duty_pct=25; valid 8 cycles after each closing edge, one pulse per period.
- Period 100 with high 1, then with high 99 -> duty_pct 1, then 99; timeout stays 0.
- High 1, period 3 -> duty_pct=33 (truncation); high 2, period 3 -> 66.
- pwm_in held 1 for 1200 cycles after a rising edge -> valid with timeout=1, duty_pct=100, high_cnt=period_cnt=1000; then a normal period 100 with high 50 -> duty_pct=50 and timeout drops to 0.
- Period 5 with high 2, continuous -> every other closing edge is dropped while busy; each valid shows duty_pct=40 and no valid ever overlaps busy.
- rst_n asserted 3 cycles after a closing edge -> no valid pulse; outputs read 0 during reset; measurement restarts from S_WAIT.
